// File: rtl/poly_encoder.sv
// poly_encoder: packs four Dilithium coefficients per beat into fixed-width
// fields and streams them out as little-endian 64-bit words.
module poly_encoder #(
    parameter int COEFF_W = 23,
    parameter int INPUT_W = 4,
    parameter int W       = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 sec_lvl,
    input  logic [2:0]                 encode_mode,
    input  logic                       valid_i,
    output logic                       ready_i,
    input  logic [INPUT_W*COEFF_W-1:0] coeffs_i,
    output logic [W-1:0]               do_o,
    output logic                       valid_o,
    output logic                       last_o,
    input  logic                       ready_o
);

    localparam int BUF_W  = 144;
    localparam int PACK_W = 80;
    localparam logic [23:0] Q = 24'd8380417;

    logic [BUF_W-1:0]  sreg_q, sreg_d;
    logic [7:0]        len_q, len_d;
    logic [5:0]        beat_cnt_q, beat_cnt_d;
    logic [6:0]        word_cnt_q, word_cnt_d;
    logic [2:0]        sec_q, sec_d;
    logic [2:0]        mode_q, mode_d;
    logic [2:0]        eff_sec, eff_mode;
    logic [4:0]        eff_len, lat_len;
    logic [23:0]       eff_off;
    logic [PACK_W-1:0] pack_bits;
    logic [6:0]        words_per_poly;
    logic              push, pop;

    // Field width for a (security level, mode) pair; zero marks an unsupported pair.
    function automatic logic [4:0] field_len(input logic [2:0] sec, input logic [2:0] mode);
        logic [4:0] l;
        l = 5'd0;
        if (sec == 3'd2 || sec == 3'd3 || sec == 3'd5) begin
            case (mode)
                3'd0:       l = 5'd13;
                3'd1:       l = 5'd10;
                3'd2, 3'd3: l = (sec == 3'd3) ? 5'd4 : 5'd3;
                3'd4:       l = (sec == 3'd2) ? 5'd6 : 5'd4;
                3'd5:       l = (sec == 3'd2) ? 5'd18 : 5'd20;
                default:    l = 5'd0;
            endcase
        end
        return l;
    endfunction

    // Centre offset for the modes that encode (offset - c) mod q.
    function automatic logic [23:0] field_off(input logic [2:0] sec, input logic [2:0] mode);
        logic [23:0] k;
        case (mode)
            3'd0:       k = 24'd4096;
            3'd2, 3'd3: k = (sec == 3'd3) ? 24'd4 : 24'd2;
            3'd5:       k = (sec == 3'd2) ? 24'd131072 : 24'd524288;
            default:    k = 24'd0;
        endcase
        return k;
    endfunction

    // The first beat of a polynomial is encoded with the live mode inputs,
    // because the latch only takes them at the end of that cycle.
    assign eff_sec        = (beat_cnt_q == 6'd0) ? sec_lvl : sec_q;
    assign eff_mode       = (beat_cnt_q == 6'd0) ? encode_mode : mode_q;
    assign eff_len        = field_len(eff_sec, eff_mode);
    assign eff_off        = field_off(eff_sec, eff_mode);
    assign lat_len        = field_len(sec_q, mode_q);
    assign words_per_poly = {lat_len, 2'b00};

    assign ready_i = (len_q < 8'd64) && !(beat_cnt_q == 6'd0 && len_q != 8'd0);
    assign valid_o = (len_q >= 8'd64);
    assign do_o    = sreg_q[W-1:0];
    assign last_o  = valid_o && (word_cnt_q == words_per_poly - 7'd1);
    assign push    = valid_i && ready_i;
    assign pop     = valid_o && ready_o;

    // Map each coefficient to its L-bit field and concatenate, field 0 lowest.
    always_comb begin
        logic [COEFF_W-1:0] c;
        logic [23:0]        x;
        logic [23:0]        mask;
        pack_bits = '0;
        mask      = (24'd1 << eff_len) - 24'd1;
        for (int j = 0; j < INPUT_W; j++) begin
            c = coeffs_i[j*COEFF_W +: COEFF_W];
            case (eff_mode)
                3'd1:    x = {14'd0, c[22:13]};
                3'd4:    x = {1'b0, c};
                default: x = ({1'b0, c} <= eff_off) ? (eff_off - {1'b0, c})
                                                    : (eff_off + Q - {1'b0, c});
            endcase
            pack_bits = pack_bits | (PACK_W'(x & mask) << (j * int'(eff_len)));
        end
    end

    // Next-state: pop drops the low word, push appends above the remaining bits.
    always_comb begin
        logic [7:0] base_len;
        base_len = pop ? (len_q - 8'd64) : len_q;
        sreg_d   = pop ? (sreg_q >> W) : sreg_q;
        len_d    = base_len;
        if (push) begin
            sreg_d = sreg_d | (BUF_W'(pack_bits) << base_len);
            len_d  = base_len + {1'b0, eff_len, 2'b00};
        end
        beat_cnt_d = push ? (beat_cnt_q + 6'd1) : beat_cnt_q;
        sec_d      = sec_q;
        mode_d     = mode_q;
        if (push && beat_cnt_q == 6'd0) begin
            sec_d  = sec_lvl;
            mode_d = encode_mode;
        end
        word_cnt_d = word_cnt_q;
        if (pop) begin
            word_cnt_d = last_o ? 7'd0 : (word_cnt_q + 7'd1);
        end
    end

    // State registers; reset drops any partial polynomial.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            sec_q      <= 3'd2;
            mode_q     <= 3'd0;
        end else begin
            sreg_q     <= sreg_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
            sec_q      <= sec_d;
            mode_q     <= mode_d;
        end
    end

endmodule
